// File: rtl/bridge_rx.sv
// Receive half of the ASCII serial bridge: parses 'R'/'W' hex frames from the UART
// byte stream and presents one registered bus request per well-formed frame.
module bridge_rx #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            axiid,
    input  logic                  axiiv,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic                  req_rw,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  frame_err
);

    localparam int NA   = ADDR_WIDTH / 4;
    localparam int ND   = DATA_WIDTH / 4;
    localparam int NMAX = (NA > ND) ? NA : ND;
    localparam int CW   = $clog2(NMAX + 1);

    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_W  = 8'h57;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        EOL
    } state_t;

    state_t                  state_q,    state_d;
    logic [CW-1:0]           cnt_q,      cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_sh_q,  addr_sh_d;
    logic [DATA_WIDTH-1:0]   data_sh_q,  data_sh_d;
    logic                    rw_sh_q,    rw_sh_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]   req_data_q, req_data_d;
    logic                    req_rw_q,   req_rw_d;
    logic                    req_valid_q, req_valid_d;
    logic                    frame_err_q, frame_err_d;

    logic       is_hex;
    logic [3:0] hex_val;
    logic       is_eol;
    logic       is_start;
    logic       abort;
    logic       start_frame;
    logic       complete;

    // Byte classification, shared by every state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        is_hex  = 1'b1;
        hex_val = 4'h0;
        if (axiid >= 8'h30 && axiid <= 8'h39) begin
            hex_val = axiid[3:0];
        end else if ((axiid >= 8'h41 && axiid <= 8'h46) ||
                     (axiid >= 8'h61 && axiid <= 8'h66)) begin
            hex_val = axiid[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
        is_eol   = (axiid == CH_CR) || (axiid == CH_LF);
        is_start = (axiid == CH_R)  || (axiid == CH_W);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        rw_sh_d     = rw_sh_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_rw_d    = req_rw_q;
        req_valid_d = req_valid_q && !req_ready;
        frame_err_d = 1'b0;
        abort       = 1'b0;
        start_frame = 1'b0;
        complete    = 1'b0;

        if (axiiv) begin
            unique case (state_q)
                IDLE: begin
                    start_frame = is_start;
                end
                ADDR: begin
                    if (is_hex) begin
                        addr_sh_d = (addr_sh_q << 4) | ADDR_WIDTH'(hex_val);
                        if (cnt_q == CW'(NA - 1)) begin
                            cnt_d   = '0;
                            state_d = rw_sh_q ? DATA : EOL;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end
                DATA: begin
                    if (is_hex) begin
                        data_sh_d = (data_sh_q << 4) | DATA_WIDTH'(hex_val);
                        if (cnt_q == CW'(ND - 1)) begin
                            cnt_d   = '0;
                            state_d = EOL;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        abort = 1'b1;
                    end
                end
                EOL: begin
                    if (is_eol) begin
                        complete = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (complete) begin
            state_d = IDLE;
            cnt_d   = '0;
            // A still-pending request wins; the new frame is reported and lost.
            if (req_valid_q && !req_ready) begin
                frame_err_d = 1'b1;
            end else begin
                req_addr_d  = addr_sh_q;
                req_data_d  = rw_sh_q ? data_sh_q : '0;
                req_rw_d    = rw_sh_q;
                req_valid_d = 1'b1;
            end
        end

        if (abort) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
            addr_sh_d   = '0;
            data_sh_d   = '0;
            start_frame = is_start;
        end

        // 'R'/'W' opens a frame from IDLE or straight out of an abort.
        if (start_frame) begin
            state_d   = ADDR;
            cnt_d     = '0;
            addr_sh_d = '0;
            data_sh_d = '0;
            rw_sh_d   = (axiid == CH_W);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            rw_sh_q     <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_rw_q    <= 1'b0;
            req_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            rw_sh_q     <= rw_sh_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_rw_q    <= req_rw_d;
            req_valid_q <= req_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign req_addr  = req_addr_q;
    assign req_data  = req_data_q;
    assign req_rw    = req_rw_q;
    assign req_valid = req_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Bench for bridge_rx: directed frames from the bridge protocol plus random frame
// streams, compared every cycle against a text-buffer model of the frame grammar.
module tb_bridge_rx;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NA = AW / 4;
    localparam int ND = DW / 4;

    logic          clk;
    logic          rst;
    logic [7:0]    axiid;
    logic          axiiv;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          req_rw;
    logic          req_valid;
    logic          req_ready;
    logic          frame_err;

    bridge_rx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .axiid     (axiid),
        .axiiv     (axiiv),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_rw    (req_rw),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model: the text of the frame in progress, and the request the bus should hold.
    logic [7:0]    fr[$];
    logic          m_valid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_rw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic int hexv(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        return int'(b) - 87;
    endfunction

    function automatic int frame_len();
        return (fr[0] == "W") ? 1 + NA + ND : 1 + NA;
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic v, input logic [7:0] b, input logic rdy);
        bit exp_err;
        bit load;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        axiiv     = v;
        axiid     = b;
        req_ready = rdy;
        @(posedge clk);
        exp_err = 0;
        load    = 0;
        a       = '0;
        d       = '0;
        if (v) begin
            if (fr.size() == 0) begin
                if (b == "R" || b == "W") fr.push_back(b);
            end else if (fr.size() < frame_len()) begin
                if (is_hex(b)) begin
                    fr.push_back(b);
                end else begin
                    exp_err = 1;
                    fr.delete();
                    if (b == "R" || b == "W") fr.push_back(b);
                end
            end else if (b == 8'h0D || b == 8'h0A) begin
                for (int i = 1; i <= NA; i++) a = (a << 4) | AW'(hexv(fr[i]));
                if (fr[0] == "W")
                    for (int i = NA + 1; i <= NA + ND; i++) d = (d << 4) | DW'(hexv(fr[i]));
                if (m_valid && !rdy) begin
                    exp_err = 1;
                end else begin
                    load   = 1;
                    m_rw   = (fr[0] == "W");
                    m_addr = a;
                    m_data = d;
                end
                fr.delete();
            end else begin
                exp_err = 1;
                fr.delete();
                if (b == "R" || b == "W") fr.push_back(b);
            end
        end
        if (load)                 m_valid = 1;
        else if (m_valid && rdy)  m_valid = 0;
        #1;
        check("frame_err", 32'(frame_err), 32'(exp_err));
        check("req_valid", 32'(req_valid), 32'(m_valid));
        if (m_valid) begin
            check("req_addr", 32'(req_addr), 32'(m_addr));
            check("req_data", 32'(req_data), 32'(m_data));
            check("req_rw",   32'(req_rw),   32'(m_rw));
        end
    endtask

    task automatic send_str(input string s, input logic rdy);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(req_valid), 32'd0);
        check({tag, "_addr"},  32'(req_addr),  32'd0);
        check({tag, "_data"},  32'(req_data),  32'd0);
        check({tag, "_rw"},    32'(req_rw),    32'd0);
        check({tag, "_err"},   32'(frame_err), 32'd0);
    endtask

    // Asynchronous reset raised between edges; outputs must clear before the next edge.
    task automatic mid_reset();
        axiiv     = 1'b0;
        req_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check_zero("async_rst");
        fr.delete();
        m_valid = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    string digits = "0123456789abcdefABCDEF";

    task automatic random_frame();
        logic [7:0] q[$];
        int kind;
        int n;
        kind = int'($urandom_range(0, 9));
        q.push_back(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52);
        n = (q[0] == 8'h57) ? NA + ND : NA;
        if (kind == 0) n = int'($urandom_range(0, n - 1));
        if (kind == 1) n = n + 1;
        for (int i = 0; i < n; i++) q.push_back(digits[$urandom_range(0, digits.len() - 1)]);
        if (kind == 2 && n > 1) q[$urandom_range(1, n)] = ($urandom_range(0, 1) == 1) ? 8'h47 : 8'h52;
        if (kind == 3) q.push_front(8'h5A);
        q.push_back(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
        if (kind >= 7) q.push_back(8'h0A);
        foreach (q[i]) begin
            idle(int'($urandom_range(0, 2)), ($urandom_range(0, 3) != 0));
            step(1'b1, q[i], ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        m_valid   = 0;
        m_addr    = '0;
        m_data    = '0;
        m_rw      = 0;
        rst       = 1'b1;
        axiiv     = 1'b0;
        axiid     = 8'h00;
        req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Plain read with CR LF; the trailing LF lands in IDLE.
        send_str("R1234\015\012", 1'b1);
        idle(2, 1'b1);

        // Write held under backpressure, then released.
        send_str("W00ABbeef\015", 1'b0);
        idle(5, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Bad digit, then a good read.
        send_str("R12G4\012", 1'b1);
        send_str("R0001\012", 1'b1);

        // Extra digit and short frame.
        send_str("R12345\012", 1'b1);
        send_str("R12\012", 1'b1);
        idle(1, 1'b1);

        // Abort that restarts as a write.
        send_str("R12W00010002\012", 1'b1);
        idle(2, 1'b1);

        // Completion while one is pending and not accepted: dropped with error.
        send_str("RAAAA\012", 1'b0);
        send_str("RBBBB\012", 1'b0);
        idle(1, 1'b1);

        // Completion coinciding with acceptance: new request replaces the old.
        send_str("RCCCC", 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        send_str("W1111222", 1'b0);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h0D, 1'b1);
        idle(2, 1'b1);

        // Reset mid-frame discards it; bare digits afterwards do nothing.
        send_str("W0001", 1'b1);
        mid_reset();
        send_str("FFFF\012", 1'b1);
        send_str("RFFFF\012", 1'b1);
        idle(2, 1'b1);

        // Reset with a request pending drops req_valid.
        send_str("W12345678\015", 1'b0);
        idle(1, 1'b0);
        mid_reset();
        idle(1, 1'b1);

        for (int f = 0; f < 150; f++) random_frame();
        idle(4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
